// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard controller: scoreboard entry layout,
// select-width helper and the hard-wired zero register number.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int REG_ZERO   = 0;

    typedef struct packed {
        logic                  we;
        logic                  is_load;
        logic [REG_AW_DEF-1:0] dst;
    } sb_entry_t;

    function automatic int sel_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source operand against one scoreboard entry, producing both the
// forwarding hit (EX-stage source) and the load-use hit (ID-stage source).
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int STAGE          = 0,
    parameter int LOAD_FWD_STAGE = 2
) (
    input  logic [REG_AW-1:0] ex_src_i,
    input  logic              ex_used_i,
    input  logic [REG_AW-1:0] id_src_i,
    input  logic              id_used_i,
    input  logic              ent_we_i,
    input  logic              ent_is_load_i,
    input  logic [REG_AW-1:0] ent_dst_i,
    output logic              fwd_hit_o,
    output logic              lu_hit_o
);

    // Entry 0 is the EX instruction itself, so it can only cause load-use stalls.
    localparam bit FWD_STAGE   = (STAGE >= 1);
    localparam bit LOAD_FWD_OK = (STAGE >= LOAD_FWD_STAGE);
    localparam bit LU_STAGE    = (STAGE <= LOAD_FWD_STAGE - 2);

    logic live;

    assign live      = ent_we_i && (ent_dst_i != REG_AW'(REG_ZERO));
    assign fwd_hit_o = FWD_STAGE && live && ex_used_i && (ent_dst_i == ex_src_i)
                       && (LOAD_FWD_OK || !ent_is_load_i);
    assign lu_hit_o  = LU_STAGE && live && ent_is_load_i && id_used_i
                       && (ent_dst_i == id_src_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: scoreboard of in-flight writers, EX forwarding
// selects, load-use stall and branch flush. HAZARD_STATS_EN adds stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int  REG_AW         = 5,
    parameter int  NUM_SRC        = 2,
    parameter int  FWD_DEPTH      = 2,
    parameter int  LOAD_FWD_STAGE = 2,
    localparam int SELW           = sel_w(FWD_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dst_addr,
    input  logic                      id_dst_we,
    input  logic                      id_is_load,
    input  logic                      ex_branch_taken,
    output logic                      stall_if,
    output logic                      bubble_ex,
    output logic                      flush,
`ifdef HAZARD_STATS_EN
    output logic [31:0]               stall_cnt,
    output logic [31:0]               flush_cnt,
`endif
    output logic [NUM_SRC*SELW-1:0]   fwd_sel
);

    typedef struct packed {
        logic              we;
        logic              is_load;
        logic [REG_AW-1:0] dst;
    } entry_t;

    entry_t [FWD_DEPTH:0]        entry_q, entry_d;
    logic [NUM_SRC*REG_AW-1:0]   ex_src_q, ex_src_d;
    logic [NUM_SRC-1:0]          ex_used_q, ex_used_d;
    logic [NUM_SRC-1:0][FWD_DEPTH:0] fwd_hit, lu_hit;
    logic [NUM_SRC*SELW-1:0]     fwd_sel_raw;
    logic                        haz, advance;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            for (gj = 0; gj <= FWD_DEPTH; gj++) begin : g_ent
                hazard_match #(
                    .REG_AW        (REG_AW),
                    .STAGE         (gj),
                    .LOAD_FWD_STAGE(LOAD_FWD_STAGE)
                ) u_match (
                    .ex_src_i     (ex_src_q[gi*REG_AW +: REG_AW]),
                    .ex_used_i    (ex_used_q[gi]),
                    .id_src_i     (id_src_addr[gi*REG_AW +: REG_AW]),
                    .id_used_i    (id_src_used[gi]),
                    .ent_we_i     (entry_q[gj].we),
                    .ent_is_load_i(entry_q[gj].is_load),
                    .ent_dst_i    (entry_q[gj].dst),
                    .fwd_hit_o    (fwd_hit[gi][gj]),
                    .lu_hit_o     (lu_hit[gi][gj])
                );
            end
        end
    endgenerate

    // Every output is forced low while reset is held, whatever the inputs do.
    assign haz       = id_valid && (|lu_hit);
    assign stall_if  = rst_n && haz && !ex_branch_taken;
    assign bubble_ex = rst_n && (haz || ex_branch_taken);
    assign flush     = rst_n && ex_branch_taken;
    assign advance   = id_valid && !stall_if && !flush;

    // Scan from the oldest stage down so the youngest matching producer wins.
    always_comb begin
        fwd_sel_raw = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = FWD_DEPTH; k >= 0; k--) begin
                if (fwd_hit[i][k]) begin
                    fwd_sel_raw[i*SELW +: SELW] = SELW'(k);
                end
            end
        end
    end

    assign fwd_sel = rst_n ? fwd_sel_raw : '0;

    always_comb begin
        entry_d   = '0;
        ex_src_d  = '0;
        ex_used_d = '0;
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            entry_d[k] = entry_q[k-1];
        end
        if (advance) begin
            entry_d[0] = '{we: id_dst_we, is_load: id_is_load, dst: id_dst_addr};
            ex_src_d   = id_src_addr;
            ex_used_d  = id_src_used;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_q   <= '0;
            ex_src_q  <= '0;
            ex_used_q <= '0;
        end else begin
            entry_q   <= entry_d;
            ex_src_q  <= ex_src_d;
            ex_used_q <= ex_used_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_if && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = rst_n ? stall_cnt_q : '0;
    assign flush_cnt = rst_n ? flush_cnt_q : '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a cycle-indexed history model of what sat in EX each
// cycle predicts every output, plus directed scenarios with literal expectations.
module tb_hazard_ctrl;

    localparam int AW  = 5;
    localparam int NS  = 2;
    localparam int D   = 2;
    localparam int LFS = 2;
    localparam int SW  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [NS*AW-1:0] id_src_addr = '0;
    logic [NS-1:0]    id_src_used = '0;
    logic [AW-1:0]    id_dst_addr = '0;
    logic             id_dst_we = 1'b0;
    logic             id_is_load = 1'b0;
    logic             ex_branch_taken = 1'b0;
    logic             stall_if, bubble_ex, flush;
    logic [NS*SW-1:0] fwd_sel;
`ifdef HAZARD_STATS_EN
    logic [31:0]      stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_AW(AW), .NUM_SRC(NS), .FWD_DEPTH(D), .LOAD_FWD_STAGE(LFS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_src_addr    (id_src_addr),
        .id_src_used    (id_src_used),
        .id_dst_addr    (id_dst_addr),
        .id_dst_we      (id_dst_we),
        .id_is_load     (id_is_load),
        .ex_branch_taken(ex_branch_taken),
        .stall_if       (stall_if),
        .bubble_ex      (bubble_ex),
        .flush          (flush),
`ifdef HAZARD_STATS_EN
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
`endif
        .fwd_sel        (fwd_sel)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: which instruction occupied EX on each cycle ----------------
    typedef struct {
        bit we;
        bit ld;
        int dst;
        int src0;
        int src1;
        bit u0;
        bit u1;
    } ins_t;

    ins_t  hist [0:2047];
    int    cyc = 0;
    ins_t  pending;
    bit    e_stall, e_bub, e_flush;
    logic [NS*SW-1:0] e_fwd;
    int    m_stall_cnt = 0;
    int    m_flush_cnt = 0;

    function automatic ins_t get(input int c);
        ins_t b;
        b = '{default: 0};
        if (c < 0 || c > 2047) return b;
        return hist[c];
    endfunction

    function automatic int srcof(input ins_t x, input int i);
        return (i == 0) ? x.src0 : x.src1;
    endfunction

    function automatic bit usedof(input ins_t x, input int i);
        return (i == 0) ? x.u0 : x.u1;
    endfunction

    always @(negedge clk) begin : cmp
        ins_t ex, e, idi, bub;
        bit   haz;
        int   s, sel;
        bub = '{default: 0};
        idi.we   = id_dst_we;
        idi.ld   = id_is_load;
        idi.dst  = int'(id_dst_addr);
        idi.src0 = int'(id_src_addr[AW-1:0]);
        idi.src1 = int'(id_src_addr[2*AW-1:AW]);
        idi.u0   = id_src_used[0];
        idi.u1   = id_src_used[1];
        ex = get(cyc);

        // Load-use: a load younger than LFS stages cannot yet supply its value.
        haz = 1'b0;
        if (id_valid) begin
            for (int i = 0; i < NS; i++) begin
                s = srcof(idi, i);
                if (usedof(idi, i) && s != 0) begin
                    for (int j = 0; j <= LFS - 2; j++) begin
                        e = get(cyc - j);
                        if (e.we && e.ld && e.dst == s) haz = 1'b1;
                    end
                end
            end
        end

        e_fwd = '0;
        if (!rst_n) begin
            e_stall = 1'b0;
            e_bub   = 1'b0;
            e_flush = 1'b0;
        end else begin
            e_stall = haz && !ex_branch_taken;
            e_bub   = haz || ex_branch_taken;
            e_flush = ex_branch_taken;
            for (int i = 0; i < NS; i++) begin
                sel = 0;
                if (usedof(ex, i) && srcof(ex, i) != 0) begin
                    for (int k = D; k >= 1; k--) begin
                        e = get(cyc - k);
                        if (e.we && e.dst == srcof(ex, i) && !(e.ld && k < LFS)) sel = k;
                    end
                end
                e_fwd[i*SW +: SW] = SW'(sel);
            end
        end
        pending = (rst_n && id_valid && !e_stall && !e_flush) ? idi : bub;

        chk("stall_if", 32'(stall_if), 32'(e_stall));
        chk("bubble_ex", 32'(bubble_ex), 32'(e_bub));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("fwd_sel", 32'(fwd_sel), 32'(e_fwd));
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", stall_cnt, rst_n ? 32'(m_stall_cnt) : 32'd0);
        chk("flush_cnt", flush_cnt, rst_n ? 32'(m_flush_cnt) : 32'd0);
`endif
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc <= 2047) hist[cyc] = pending;
        if (!rst_n) begin
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (e_stall) m_stall_cnt = m_stall_cnt + 1;
            if (e_flush) m_flush_cnt = m_flush_cnt + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int s0, input int s1, input bit u0, input bit u1,
                         input int dst, input bit we, input bit ld, input bit br, input bit rn);
        @(posedge clk);
        #1;
        rst_n           = rn;
        id_valid        = v;
        id_src_addr     = {AW'(s1), AW'(s0)};
        id_src_used     = {u1, u0};
        id_dst_addr     = AW'(dst);
        id_dst_we       = we;
        id_is_load      = ld;
        ex_branch_taken = br;
        @(negedge clk);
        $display("cyc %0d rst_n=%0b v=%0b src=%0d,%0d used=%0b%0b dst=%0d we=%0b ld=%0b br=%0b -> stall=%0b bubble=%0b flush=%0b fwd=%0h",
                 cyc, rn, v, s0, s1, u1, u0, dst, we, ld, br, stall_if, bubble_ex, flush, fwd_sel);
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic alu(input int dst, input int s0, input int s1);
        drive(1, s0, s1, 1, 1, dst, 1, 0, 0, 1);
    endtask

    task automatic lw(input int dst, input int base);
        drive(1, base, 0, 1, 0, dst, 1, 1, 0, 1);
    endtask

    initial begin
        // Reset with aggressive inputs: everything must stay low.
        for (int r = 0; r < 3; r++) begin
            drive(1, 5, 5, 1, 1, 5, 1, 1, 1, 0);
            chk("rst_stall", 32'(stall_if), 32'd0);
            chk("rst_bubble", 32'(bubble_ex), 32'd0);
            chk("rst_flush", 32'(flush), 32'd0);
            chk("rst_fwd", 32'(fwd_sel), 32'd0);
        end
        alu(9, 5, 5);
        chk("post_rst_stall", 32'(stall_if), 32'd0);
        nop();
        chk("post_rst_fwd", 32'(fwd_sel), 32'd0);

        // Forwarding distance 1, 2 and out of range.
        nop(); nop();
        alu(3, 10, 11); alu(4, 3, 1); nop();
        chk("fwd_gap0", 32'(fwd_sel), 32'h1);
        alu(3, 10, 11); nop(); alu(4, 3, 1); nop();
        chk("fwd_gap1", 32'(fwd_sel), 32'h2);
        alu(3, 10, 11); nop(); nop(); alu(4, 3, 1); nop();
        chk("fwd_gap2", 32'(fwd_sel), 32'h0);

        // Load-use: one stall cycle, then forward from MEM/WB.
        nop(); nop();
        lw(5, 10);
        alu(6, 5, 5);
        chk("lu_stall", 32'(stall_if), 32'd1);
        chk("lu_bubble", 32'(bubble_ex), 32'd1);
        alu(6, 5, 5);
        chk("lu_release", 32'(stall_if), 32'd0);
        nop();
        chk("lu_fwd", 32'(fwd_sel), 32'hA);
`ifdef HAZARD_STATS_EN
        chk("lu_stall_cnt", stall_cnt, 32'd1);
`endif

        // Register zero is never forwarded and never stalls.
        nop(); nop();
        alu(0, 10, 11); alu(12, 0, 0); nop();
        chk("r0_fwd", 32'(fwd_sel), 32'd0);
        lw(0, 10); alu(13, 0, 0);
        chk("r0_stall", 32'(stall_if), 32'd0);
        nop();

        // Hazard and taken branch together: flush wins, ID instruction dropped.
        nop(); nop();
        lw(5, 10);
        drive(1, 5, 5, 1, 1, 8, 1, 0, 1, 1);
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_stall", 32'(stall_if), 32'd0);
        chk("br_bubble", 32'(bubble_ex), 32'd1);
        alu(14, 8, 8);
        chk("br_next_stall", 32'(stall_if), 32'd0);
`ifdef HAZARD_STATS_EN
        chk("br_flush_cnt", flush_cnt, 32'd1);
`endif
        nop();
        chk("br_dropped", 32'(fwd_sel), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("br_only_flush", 32'(flush), 32'd1);
        chk("br_only_stall", 32'(stall_if), 32'd0);

        // Two in-flight writers of r7: youngest wins.
        nop(); nop();
        alu(7, 10, 11); alu(7, 12, 13); alu(15, 7, 7); nop();
        chk("youngest_fwd", 32'(fwd_sel), 32'h5);

        // Reset in the middle of a stall drops it.
        nop(); nop();
        lw(5, 10);
        alu(6, 5, 5);
        chk("ms_stall", 32'(stall_if), 32'd1);
        drive(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
        chk("ms_rst_stall", 32'(stall_if), 32'd0);
        chk("ms_rst_bubble", 32'(bubble_ex), 32'd0);
        alu(6, 5, 5);
        chk("ms_after_stall", 32'(stall_if), 32'd0);
`ifdef HAZARD_STATS_EN
        chk("ms_stall_cnt", stall_cnt, 32'd0);
`endif
        nop();
        chk("ms_after_fwd", 32'(fwd_sel), 32'd0);
        nop();

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
